// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - size encodings for req_size
//   - controller state enum
//   - WORD_W: data word width
//   - is_misaligned(): alignment check on the two low byte-address bits
package lsu_pkg;

    localparam int WORD_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_GAP,
        ST_WR,
        ST_RESP
    } state_t;

    // Bytes are always aligned; halves need an even address, words a
    // multiple of four. The reserved size is reported separately.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit (big-endian:
// byte offset 0 is bits 31:24, half offset 0 is bits 31:16).
// Ports:
//   size        request size (lsu_pkg SZ_* encoding)
//   offset      byte address bits [1:0]
//   is_unsigned 1 = zero-extend loads, 0 = sign-extend
//   rdata       word read from memory
//   wdata       right-justified store data
//   load_data   extracted and extended load result
//   merged      rdata with the addressed lane(s) replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    input  logic [WORD_W-1:0] rdata,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] load_data,
    output logic [WORD_W-1:0] merged
);

    logic [WORD_W-1:0] byte_shift;
    logic [WORD_W-1:0] half_shift;

    // ~offset equals 3-offset, so the addressed lane lands in the low bits.
    assign byte_shift = rdata >> {~offset, 3'b000};
    assign half_shift = rdata >> {~offset[1], 4'b0000};

    always_comb begin
        load_data = rdata;
        case (size)
            SZ_BYTE: load_data = is_unsigned ? {24'b0, byte_shift[7:0]}
                                             : {{24{byte_shift[7]}}, byte_shift[7:0]};
            SZ_HALF: load_data = is_unsigned ? {16'b0, half_shift[15:0]}
                                             : {{16{half_shift[15]}}, half_shift[15:0]};
            default: load_data = rdata;
        endcase
    end

    // Lane gi holds bits [8*gi+7 : 8*gi]; lane 3 is byte offset 0.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_hit;
            logic [7:0] lane_src;

            always_comb begin
                lane_hit = 1'b1;
                lane_src = wdata[8*gi +: 8];
                case (size)
                    SZ_BYTE: begin
                        lane_hit = (offset == 2'(3 - gi));
                        lane_src = wdata[7:0];
                    end
                    SZ_HALF: begin
                        // Offset 0 covers lanes 3,2; offset 2 covers lanes 1,0.
                        lane_hit = (offset[1] == (gi < 2));
                        lane_src = (gi % 2 == 1) ? wdata[15:8] : wdata[7:0];
                    end
                    default: begin
                        lane_hit = 1'b1;
                        lane_src = wdata[8*gi +: 8];
                    end
                endcase
            end

            assign merged[8*gi +: 8] = lane_hit ? lane_src : rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of the MEM-stage data memory.
// Accepts byte/half/word requests over valid/ready, rejects misaligned or
// reserved-size requests, and drives the memory's edge-triggered read and
// write strobes. Sub-word stores are read-modify-write with a one-cycle
// gap between the read and write strobes.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   req_*                          request channel (byte address, big-endian)
//   resp_valid/ready/rdata/error   response channel
//   mem_read_addr, mem_trig_read   memory read port (word address, strobe)
//   mem_write_addr/data, mem_trig_write  memory write port
//   mem_read_data                  memory read data
//   stat_loads/stores/errors       saturating counters, only with
//                                  LSU_STATS_EN defined
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int WORD_AW = 7,
    parameter int STAT_W  = 16
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WORD_AW+1:0] req_addr,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WORD_W-1:0]  resp_rdata,
    output logic               resp_error,
    output logic [WORD_AW-1:0] mem_read_addr,
    output logic [WORD_AW-1:0] mem_write_addr,
    output logic [WORD_W-1:0]  mem_write_data,
    output logic               mem_trig_read,
    output logic               mem_trig_write,
    input  logic [WORD_W-1:0]  mem_read_data
`ifdef LSU_STATS_EN
    ,
    output logic [STAT_W-1:0]  stat_loads,
    output logic [STAT_W-1:0]  stat_stores,
    output logic [STAT_W-1:0]  stat_errors
`endif
);

    state_t            state;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              uns_q;
    logic              write_q;
    logic [WORD_W-1:0] wdata_q;
    logic [WORD_W-1:0] load_data;
    logic [WORD_W-1:0] merged;
    logic              req_err;

    assign req_err = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);

    lsu_lane_align u_align (
        .size        (size_q),
        .offset      (off_q),
        .is_unsigned (uns_q),
        .rdata       (mem_read_data),
        .wdata       (wdata_q),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_error     <= 1'b0;
            resp_rdata     <= '0;
            mem_read_addr  <= '0;
            mem_write_addr <= '0;
            mem_write_data <= '0;
            mem_trig_read  <= 1'b0;
            mem_trig_write <= 1'b0;
            size_q         <= '0;
            off_q          <= '0;
            uns_q          <= 1'b0;
            write_q        <= 1'b0;
            wdata_q        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        size_q    <= req_size;
                        off_q     <= req_addr[1:0];
                        uns_q     <= req_unsigned;
                        write_q   <= req_write;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err) begin
                            // Rejected requests never touch memory.
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= '0;
                            state      <= ST_RESP;
                        end else if (req_write && req_size == SZ_WORD) begin
                            mem_write_addr <= req_addr[WORD_AW+1:2];
                            mem_write_data <= req_wdata;
                            mem_trig_write <= 1'b1;
                            state          <= ST_WR;
                        end else begin
                            // Loads and sub-word stores both start with a read.
                            mem_read_addr  <= req_addr[WORD_AW+1:2];
                            mem_write_addr <= req_addr[WORD_AW+1:2];
                            mem_trig_read  <= 1'b1;
                            state          <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    mem_trig_read <= 1'b0;
                    if (write_q) begin
                        mem_write_data <= merged;
                        state          <= ST_GAP;
                    end else begin
                        resp_rdata <= load_data;
                        resp_error <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_GAP: begin
                    // The memory only writes while its read strobe is low,
                    // so the write strobe waits one full idle cycle.
                    mem_trig_write <= 1'b1;
                    state          <= ST_WR;
                end
                ST_WR: begin
                    mem_trig_write <= 1'b0;
                    resp_rdata     <= '0;
                    resp_error     <= 1'b0;
                    resp_valid     <= 1'b1;
                    state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        resp_error <= 1'b0;
                        resp_rdata <= '0;
                        req_ready  <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    mem_trig_read  <= 1'b0;
                    mem_trig_write <= 1'b0;
                    resp_valid     <= 1'b0;
                    req_ready      <= 1'b1;
                    state          <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errors <= '0;
        end else if (state == ST_RESP && resp_ready) begin
            if (resp_error) begin
                if (stat_errors != '1) stat_errors <= stat_errors + 1'b1;
            end else if (write_q) begin
                if (stat_stores != '1) stat_stores <= stat_stores + 1'b1;
            end else begin
                if (stat_loads != '1) stat_loads <= stat_loads + 1'b1;
            end
        end
    end
`endif

endmodule
